db9_joy_serial_reader: RTL and testbench

//  Scans the middleboard's DB9 joystick shift-register chain (74HC165-style, parallel-load active-low).

---
 rtl/db9_joy_serial_reader.sv | 165 ++++++++++++++++
 tb/tb_db9_joy_serial_reader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/db9_joy_serial_reader.sv
// -----------------------------------------------------------------------------
// db9_joy_serial_reader
//
// Scans a 74HC165-style shift-register chain carrying two DB9 joysticks and
// presents the buttons as active-high words.
//
// Scan sequence (one state per divider tick):
//   IDLE   x IDLE_TICKS  load=1 clk=1
//   LOAD   x 1           load=0 clk=1   (chain parallel-loads, bit 0 on data)
//   SAMPLE x 2*JOY_BITS  load=1 clk=1   (synced data stored at the tick)
//   CLKLO  x 2*JOY_BITS-1       clk=0   (rising edge on exit shifts next bit)
//   END    one clk_sys cycle after the last SAMPLE tick, inside the next IDLE
//          tick; frame_vld is high here and joy1/joy2 already show the frame.
// The scan therefore takes IDLE_TICKS + 4*JOY_BITS ticks per frame.
//
// Ports:
//   clk_sys   in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   joy_clk   out  shift clock to the chain, idle high
//   joy_load  out  parallel load to the chain, active low
//   joy_data  in   serial chain data, asynchronous, active low per button
//   joy1      out  joystick 1 {start,f3,f2,f1,right,left,down,up}, 1=pressed
//   joy2      out  joystick 2, same mapping
//   frame_vld out  one-cycle pulse at the end of every completed frame
// -----------------------------------------------------------------------------
module db9_joy_serial_reader #(
    parameter int CLK_DIV    = 6,
    parameter int IDLE_TICKS = 8,
    parameter int JOY_BITS   = 8,
    parameter int FILTER     = 1
) (
    input  logic                clk_sys,
    input  logic                reset,
    output logic                joy_clk,
    output logic                joy_load,
    input  logic                joy_data,
    output logic [JOY_BITS-1:0] joy1,
    output logic [JOY_BITS-1:0] joy2,
    output logic                frame_vld
);

    localparam int FRAME_BITS = 2 * JOY_BITS;
    localparam int DIV_W      = $clog2(CLK_DIV);
    localparam int IDLE_W     = $clog2(IDLE_TICKS + 1);
    localparam int CNT_W      = $clog2(FRAME_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SAMPLE,
        S_CLKLO,
        S_END
    } state_t;

    state_t                  state_reg, state_next;
    logic [DIV_W-1:0]        div_reg;
    logic [IDLE_W-1:0]       idle_reg, idle_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [FRAME_BITS-1:0]   frame_reg, frame_next;
    logic [FRAME_BITS-1:0]   prev_reg;
    logic [1:0]              sync_reg;
    logic                    joy_clk_reg, joy_load_reg, frame_vld_reg;
    logic [JOY_BITS-1:0]     joy1_reg, joy2_reg;
    logic                    tick;
    logic                    synced;
    logic                    last_bit;
    logic                    frame_done;
    logic                    take_frame;

    assign tick     = (div_reg == DIV_W'(CLK_DIV - 1));
    assign synced   = sync_reg[1];
    assign last_bit = (cnt_reg == CNT_W'(FRAME_BITS - 1));

    // Final sample of the frame: frame_next already holds the complete word.
    assign frame_done = (state_reg == S_SAMPLE) && tick && last_bit;
    assign take_frame = (FILTER == 0) || (frame_next == prev_reg);

    always_comb begin
        state_next = state_reg;
        idle_next  = idle_reg;
        cnt_next   = cnt_reg;
        frame_next = frame_reg;
        case (state_reg)
            S_IDLE: begin
                if (tick) begin
                    if (idle_reg == IDLE_W'(IDLE_TICKS - 1)) begin
                        idle_next  = '0;
                        state_next = S_LOAD;
                    end else begin
                        idle_next = idle_reg + IDLE_W'(1);
                    end
                end
            end
            S_LOAD: begin
                if (tick) state_next = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (tick) begin
                    frame_next[cnt_reg] = synced;
                    if (last_bit) begin
                        state_next = S_END;
                    end else begin
                        cnt_next   = cnt_reg + CNT_W'(1);
                        state_next = S_CLKLO;
                    end
                end
            end
            S_CLKLO: begin
                if (tick) state_next = S_SAMPLE;
            end
            S_END: begin
                // Never coincides with a tick (CLK_DIV >= 4), so the idle
                // counter loses nothing by skipping this cycle.
                cnt_next   = '0;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            div_reg       <= '0;
            idle_reg      <= '0;
            cnt_reg       <= '0;
            frame_reg     <= '1;
            prev_reg      <= '1;
            sync_reg      <= 2'b11;
            joy_clk_reg   <= 1'b1;
            joy_load_reg  <= 1'b1;
            frame_vld_reg <= 1'b0;
            joy1_reg      <= '0;
            joy2_reg      <= '0;
        end else begin
            sync_reg  <= {sync_reg[0], joy_data};
            div_reg   <= tick ? '0 : div_reg + DIV_W'(1);
            state_reg <= state_next;
            idle_reg  <= idle_next;
            cnt_reg   <= cnt_next;
            frame_reg <= frame_next;
            // Pins follow the state being entered, so they line up with the
            // state register and can only move on a state change.
            joy_clk_reg   <= (state_next != S_CLKLO);
            joy_load_reg  <= (state_next != S_LOAD);
            frame_vld_reg <= frame_done;
            if (frame_done) begin
                prev_reg <= frame_next;
                if (take_frame) begin
                    joy1_reg <= ~frame_next[JOY_BITS-1:0];
                    joy2_reg <= ~frame_next[FRAME_BITS-1:JOY_BITS];
                end
            end
        end
    end

    assign joy_clk   = joy_clk_reg;
    assign joy_load  = joy_load_reg;
    assign joy1      = joy1_reg;
    assign joy2      = joy2_reg;
    assign frame_vld = frame_vld_reg;

endmodule

// File: tb/tb_db9_joy_serial_reader.sv
// -----------------------------------------------------------------------------
// Bench for db9_joy_serial_reader: two instances (FILTER=0 and FILTER=1) each
// drive their own behavioural 16-bit 74HC165 chain loaded from a shared
// parallel value. Expected joystick words are queued when a frame is issued
// and popped by a monitor on every frame_vld; a second monitor checks pin
// timing of the FILTER=0 instance.
// -----------------------------------------------------------------------------
module tb_db9_joy_serial_reader;

    localparam int CLK_DIV    = 4;
    localparam int IDLE_TICKS = 4;
    localparam int JOY_BITS   = 8;
    // IDLE + LOAD + 16 SAMPLE + 15 CLKLO ticks
    localparam int FRAME_CYC  = (IDLE_TICKS + 1 + 2*JOY_BITS + 2*JOY_BITS - 1) * CLK_DIV;

    typedef struct packed {
        logic [7:0] j1;
        logic [7:0] j2;
    } exp_t;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_sys = ~clk_sys;

    logic [15:0] par = 16'hFFFF;
    logic        glitch = 1'b0;
    logic        glitch_en = 1'b0;

    logic       clk0, load0, data0, vld0;
    logic       clk1, load1, data1, vld1;
    logic [7:0] j1_0, j2_0, j1_1, j2_1;
    logic [15:0] sr0 = 16'hFFFF;
    logic [15:0] sr1 = 16'hFFFF;

    assign data0 = sr0[0] ^ glitch;
    assign data1 = sr1[0] ^ glitch;

    // 74HC165 chain models: asynchronous parallel load while load is low,
    // shift toward the output on each rising clock.
    always @(negedge load0 or posedge clk0)
        if (!load0) sr0 <= par; else sr0 <= {1'b1, sr0[15:1]};
    always @(negedge load1 or posedge clk1)
        if (!load1) sr1 <= par; else sr1 <= {1'b1, sr1[15:1]};

    db9_joy_serial_reader #(.CLK_DIV(CLK_DIV), .IDLE_TICKS(IDLE_TICKS),
                            .JOY_BITS(JOY_BITS), .FILTER(0)) u_f0 (
        .clk_sys(clk_sys), .reset(reset), .joy_clk(clk0), .joy_load(load0),
        .joy_data(data0), .joy1(j1_0), .joy2(j2_0), .frame_vld(vld0));

    db9_joy_serial_reader #(.CLK_DIV(CLK_DIV), .IDLE_TICKS(IDLE_TICKS),
                            .JOY_BITS(JOY_BITS), .FILTER(1)) u_f1 (
        .clk_sys(clk_sys), .reset(reset), .joy_clk(clk1), .joy_load(load1),
        .joy_data(data1), .joy1(j1_1), .joy2(j2_1), .frame_vld(vld1));

    int   tests = 0;
    int   fails = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [15:0] m_prev = 16'hFFFF;
    exp_t        m_out  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Queue one frame: parallel chain value plus hand-computed decoded words.
    task automatic issue(input logic [15:0] p, input logic [7:0] e1, input logic [7:0] e2);
        par = p;
        q0.push_back('{j1: e1, j2: e2});
        if (p == m_prev) m_out = '{j1: e1, j2: e2};
        m_prev = p;
        q1.push_back(m_out);
        $display("[TB] issue chain=%h expect f0=%h/%h f1=%h/%h", p, e1, e2, m_out.j1, m_out.j2);
    endtask

    task automatic wait_vld();
        int k = 0;
        do begin
            @(negedge clk_sys);
            k++;
        end while (!vld0 && k < 2000);
        check("vld_timeout", {31'd0, vld0}, 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_clk0"}, {31'd0, clk0}, 32'd1);
        check({tag, "_load0"}, {31'd0, load0}, 32'd1);
        check({tag, "_joy0"}, {16'd0, j1_0, j2_0}, 32'd0);
        check({tag, "_vld0"}, {31'd0, vld0}, 32'd0);
        check({tag, "_clk1"}, {31'd0, clk1}, 32'd1);
        check({tag, "_load1"}, {31'd0, load1}, 32'd1);
        check({tag, "_joy1"}, {16'd0, j1_1, j2_1}, 32'd0);
        check({tag, "_vld1"}, {31'd0, vld1}, 32'd0);
    endtask

    // Scoreboard monitor.
    initial forever begin
        exp_t e;
        @(negedge clk_sys);
        if (vld0) begin
            if (q0.size() == 0) begin
                check("f0_unexpected_vld", {31'd0, vld0}, 32'd0);
            end else begin
                e = q0.pop_front();
                check("f0_joy1", {24'd0, j1_0}, {24'd0, e.j1});
                check("f0_joy2", {24'd0, j2_0}, {24'd0, e.j2});
                $display("[TB] f0 frame joy1=%h joy2=%h", j1_0, j2_0);
            end
        end
        if (vld1) begin
            if (q1.size() == 0) begin
                check("f1_unexpected_vld", {31'd0, vld1}, 32'd0);
            end else begin
                e = q1.pop_front();
                check("f1_joy1", {24'd0, j1_1}, {24'd0, e.j1});
                check("f1_joy2", {24'd0, j2_1}, {24'd0, e.j2});
                $display("[TB] f1 frame joy1=%h joy2=%h", j1_1, j2_1);
            end
        end
    end

    // Pin timing monitor on the FILTER=0 instance.
    initial begin
        int  cyc = 0, last_vld = 0, load_run = 0, clk_run = 0, pulses = 0;
        bit  have_last = 0;
        logic vld_prev = 1'b0;
        forever begin
            @(negedge clk_sys);
            cyc++;
            if (reset) begin
                have_last = 0;
                load_run  = 0;
                clk_run   = 0;
                vld_prev  = 1'b0;
            end else begin
                if (!load0) begin
                    load_run++;
                    if (load_run == 1) pulses = 0;
                end else if (load_run != 0) begin
                    check("load_low_width", load_run, CLK_DIV);
                    load_run = 0;
                end
                if (!clk0) begin
                    clk_run++;
                end else if (clk_run != 0) begin
                    check("clk_low_width", clk_run, CLK_DIV);
                    pulses++;
                    clk_run = 0;
                end
                if (!load0 && !clk0) check("load_while_clk_low", 32'd1, 32'd0);
                if (vld0 && vld_prev) check("vld_single_cycle", 32'd1, 32'd0);
                if (vld0) begin
                    check("clk_pulses_per_frame", pulses, 2*JOY_BITS - 1);
                    if (have_last) check("frame_period", cyc - last_vld, FRAME_CYC);
                    last_vld  = cyc;
                    have_last = 1;
                end
                vld_prev = vld0;
            end
        end
    end

    // Asynchronous toggling of the data line, confined to clk-low phases.
    initial forever begin
        @(negedge clk0);
        if (glitch_en) begin
            for (int i = 0; i < 4; i++) begin
                #($urandom_range(1, 8));
                glitch = ~glitch;
            end
            glitch = 1'b0;
        end
    end

    initial begin
        int n;
        int r;
        logic prev_clk;

        // T1: reset state and first load position
        issue(16'hFE7F, 8'h80, 8'h01);
        reset = 1'b1;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        check_reset_state("rst");
        reset = 1'b0;
        n = 0;
        while (load0 && n < 200) begin
            @(posedge clk_sys);
            n++;
            #1;
        end
        check("first_load_cycles", n, IDLE_TICKS * CLK_DIV);

        // T3/T4: mapping and filtering
        wait_vld(); issue(16'hFE7F, 8'h80, 8'h01);
        wait_vld(); issue(16'h5AA5, 8'h5A, 8'hA5);
        wait_vld(); issue(16'h3C0F, 8'hF0, 8'hC3);
        wait_vld(); issue(16'h3C0F, 8'hF0, 8'hC3);
        wait_vld();
        // T6: asynchronous activity on joy_data while clk is low
        glitch_en = 1'b1;
        issue(16'h00FF, 8'h00, 8'hFF);
        wait_vld(); issue(16'h00FF, 8'h00, 8'hFF);
        wait_vld();
        glitch_en = 1'b0;

        // T5: reset in the middle of a frame
        issue(16'h1234, 8'hCB, 8'hED);
        n = 0;
        while (load0 && n < 500) begin
            @(negedge clk_sys);
            n++;
        end
        check("t5_load_seen", {31'd0, load0}, 32'd0);
        r = 0;
        n = 0;
        prev_clk = clk0;
        while (r < 9 && n < 500) begin
            @(negedge clk_sys);
            n++;
            if (clk0 && !prev_clk) r++;
            prev_clk = clk0;
        end
        n = 0;
        while (clk0 && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        check("t5_clk_low_seen", {31'd0, clk0}, 32'd0);
        reset = 1'b1;
        q0.delete();
        q1.delete();
        m_prev = 16'hFFFF;
        m_out  = '0;
        @(negedge clk_sys);
        check_reset_state("midrst");
        repeat (2) @(negedge clk_sys);
        issue(16'h1234, 8'hCB, 8'hED);
        reset = 1'b0;
        wait_vld(); issue(16'h1234, 8'hCB, 8'hED);
        wait_vld();
        repeat (4) @(negedge clk_sys);
        check("q0_drained", q0.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
